// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: clock generator, bit synchronizer and a 3rd-order CIC decimator.
// Latency: sample_out updates 2 cycles after the decimation tick. The first 3 outputs after reset are suppressed.
// No backpressure: sample_valid is a level strobe CLK_DIV/2 cycles wide, and the consumer detects its rising edge.
module pdm_cic_decimator #(
  parameter int CLK_DIV   = 32,  // system clocks per pdm_clk period, even and >= 4
  parameter int DECIM     = 16,  // CIC decimation ratio: 2, 4, 8 or 16
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pdm_data,
  output logic                        pdm_clk,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        sample_valid
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = 3 * LOG2D + 2;
  localparam int STR_W = $clog2(CLK_DIV / 2);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [LOG2D-1:0] DEC_LAST = LOG2D'(DECIM - 1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(CLK_DIV / 2 - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             sync_1;
  logic             sync_2;
  logic             tick;
  logic             dec_tick;
  logic [LOG2D-1:0] dec_cnt;

  // Integrator state and next values. All of it wraps modulo 2^ACC_W.
  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] i1, i2, i3;
  logic [ACC_W-1:0] i1_n, i2_n, i3_n;

  // Comb delay registers and combinational comb chain
  logic [ACC_W-1:0] d1, d2, d3;
  logic [ACC_W-1:0] c1, c2, c3;
  logic [ACC_W-1:0] comb_out;
  logic             out_en;

  logic [1:0]           warm_cnt;
  logic [STR_W-1:0]     str_cnt;
  logic [OUT_WIDTH-1:0] scaled;

  // Divider wrap, bit tick and decimation tick decode
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    div_nxt  = tick ? '0 : div_cnt + 1'b1;
    dec_tick = tick && (dec_cnt == DEC_LAST);
  end

  // Map the bit to +1/-1 and evaluate the integrator cascade and combs for this tick
  always_comb begin
    x    = sync_2 ? ACC_W'(1) : {ACC_W{1'b1}};
    i1_n = i1 + x;
    i2_n = i2 + i1_n;
    i3_n = i3 + i2_n;
    c1   = i3_n - d1;
    c2   = c1 - d2;
    c3   = c2 - d3;
  end

  // Align the comb result to the output width: left shift, or keep the MSBs when narrower
  generate
    if (OUT_WIDTH > ACC_W) begin : g_widen
      assign scaled = {comb_out, {(OUT_WIDTH - ACC_W){1'b0}}};
    end else if (OUT_WIDTH == ACC_W) begin : g_same
      assign scaled = comb_out;
    end else begin : g_narrow
      assign scaled = comb_out[ACC_W-1 -: OUT_WIDTH];
    end
  endgenerate

  // Free-running divider. pdm_clk is registered from the next count, so it tracks div_cnt exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pdm_clk <= (div_nxt >= DIV_HALF);
    end
  end

  // Two-flop synchronizer for the asynchronous microphone data
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= pdm_data;
      sync_2 <= sync_1;
    end
  end

  // Integrators and decimation counter advance once per bit tick
  always_ff @(posedge clk) begin
    if (rst) begin
      i1      <= '0;
      i2      <= '0;
      i3      <= '0;
      dec_cnt <= '0;
    end else if (tick) begin
      i1      <= i1_n;
      i2      <= i2_n;
      i3      <= i3_n;
      dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
    end
  end

  // Combs run on the decimation tick, using the integrator value that includes this tick's bit
  always_ff @(posedge clk) begin
    if (rst) begin
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      comb_out <= '0;
      out_en   <= 1'b0;
    end else begin
      out_en <= dec_tick;
      if (dec_tick) begin
        d1       <= i3_n;
        d2       <= c1;
        d3       <= c2;
        comb_out <= c3;
      end
    end
  end

  // Output stage: drop the warm-up outputs, then publish each sample with a CLK_DIV/2-cycle strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt     <= '0;
      str_cnt      <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else if (out_en) begin
      if (warm_cnt != 2'd3) begin
        warm_cnt <= warm_cnt + 2'd1;
      end else begin
        sample_out   <= scaled;
        sample_valid <= 1'b1;
        str_cnt      <= STR_LAST;
      end
    end else if (str_cnt != '0) begin
      str_cnt <= str_cnt - 1'b1;
    end else begin
      sample_valid <= 1'b0;
    end
  end

endmodule
